// File: rtl/l2_access_arbiter_pkg.sv
// Shared definitions for the L2 access arbiter: FSM state encodings,
// grant identifiers, enable levels and datapath widths.
package l2_access_arbiter_pkg;

  // Arbiter FSM states, 3 bits wide to match the other cache controllers.
  typedef enum logic [2:0] {
    ARB_IDLE = 3'd0,
    ARB_IC   = 3'd1,
    ARB_DC   = 3'd2,
    ARB_GAP  = 3'd3
  } arb_state_e;

  // Identity of the requester that received the most recent grant.
  typedef enum logic {
    GRANT_IC = 1'b0,
    GRANT_DC = 1'b1
  } grant_e;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

endpackage

// File: rtl/l2_arb_watchdog.sv
// Grant watchdog: counts cycles while a grant is held and flags the cycle in
// which the TIMEOUT-th consecutive grant cycle is reached.
module l2_arb_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  // Count value seen during the TIMEOUT-th grant cycle (count starts at 0).
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Cycle counter: cleared outside a grant, advances once per grant cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with <= so every register samples
    // pre-edge values; blocking writes here would create ordering races.
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = enable && (count == LAST_CNT);

endmodule

// File: rtl/l2_access_arbiter.sv
// L2 access arbiter: shares the single L2 port between the I-cache and
// D-cache miss paths. One owner at a time, grant held until l2_done, owner
// abort or watchdog expiry, then one dead cycle before re-arbitration.
// All outputs are registered.
//
// Build option: define L2_ARB_RR_EN to resolve simultaneous requests
// round-robin against the last grant; otherwise the D-cache always wins.
module l2_access_arbiter
  import l2_access_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              irq,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_rw,
  input  logic              drq,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_rw,
  input  logic [DATA_W-1:0] dc_wd,
  input  logic              l2_done,
  output logic              ic_en,
  output logic              dc_en,
  output logic              l2_req,
  output logic [ADDR_W-1:0] l2_addr,
  output logic              l2_rw,
  output logic [DATA_W-1:0] l2_wd,
  output logic              arb_busy,
  output logic              arb_timeout
);

  arb_state_e        state;
  arb_state_e        state_next;
  logic              granted;
  logic              arbitrating;
  logic              expire;
  logic              pick_ic;
  logic              pick_dc;
  logic              timeout_next;
  logic [ADDR_W-1:0] addr_next;
  logic              rw_next;
  logic [DATA_W-1:0] wd_next;

  assign granted     = (state == ARB_IC) || (state == ARB_DC);
  assign arbitrating = (state == ARB_IDLE) || (state == ARB_GAP);

  l2_arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (!granted),
    .enable (granted),
    .expire (expire)
  );

`ifdef L2_ARB_RR_EN
  grant_e last_grant;

  // Remember who was granted last so a tie goes to the other requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GRANT_DC;
    end else if (arbitrating && pick_ic) begin
      last_grant <= GRANT_IC;
    end else if (arbitrating && pick_dc) begin
      last_grant <= GRANT_DC;
    end
  end
`endif

  // Arbitration decision from the current requests.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    pick_ic = DISABLE;
    pick_dc = DISABLE;
    if (irq && drq) begin
`ifdef L2_ARB_RR_EN
      if (last_grant == GRANT_DC) pick_ic = ENABLE;
      else                        pick_dc = ENABLE;
`else
      pick_dc = ENABLE;
`endif
    end else if (drq) begin
      pick_dc = ENABLE;
    end else if (irq) begin
      pick_ic = ENABLE;
    end
  end

  // Next state, timeout pulse and the next values of the muxed L2 datapath.
  always_comb begin
    state_next   = state;
    timeout_next = DISABLE;
    unique case (state)
      ARB_IDLE, ARB_GAP: begin
        if (pick_dc)      state_next = ARB_DC;
        else if (pick_ic) state_next = ARB_IC;
        else              state_next = ARB_IDLE;
      end
      ARB_IC: begin
        if (l2_done || !irq || expire) state_next = ARB_GAP;
        timeout_next = expire && !l2_done;
      end
      ARB_DC: begin
        if (l2_done || !drq || expire) state_next = ARB_GAP;
        timeout_next = expire && !l2_done;
      end
      default: state_next = ARB_IDLE;
    endcase

    addr_next = '0;
    rw_next   = 1'b0;
    wd_next   = '0;
    if (state_next == ARB_IC) begin
      addr_next = ic_addr;
      rw_next   = ic_rw;
    end else if (state_next == ARB_DC) begin
      addr_next = dc_addr;
      rw_next   = dc_rw;
      wd_next   = dc_wd;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_next;
  end

  // Output registers, loaded from the upcoming state so grants appear one
  // cycle after the request is seen and drop one cycle after the exit event.
  always_ff @(posedge clk) begin
    if (rst) begin
      ic_en       <= 1'b0;
      dc_en       <= 1'b0;
      l2_req      <= 1'b0;
      l2_addr     <= '0;
      l2_rw       <= 1'b0;
      l2_wd       <= '0;
      arb_busy    <= 1'b0;
      arb_timeout <= 1'b0;
    end else begin
      ic_en       <= (state_next == ARB_IC);
      dc_en       <= (state_next == ARB_DC);
      l2_req      <= (state_next == ARB_IC) || (state_next == ARB_DC);
      l2_addr     <= addr_next;
      l2_rw       <= rw_next;
      l2_wd       <= wd_next;
      arb_busy    <= (state_next == ARB_IC) || (state_next == ARB_DC);
      arb_timeout <= timeout_next;
    end
  end

endmodule
